bus_serializer: RTL

BUS_SERIALIZER -- requirements
Module: bus_serializer

---
 rtl/bus_ser_pkg.sv | 17 +
 rtl/bus_ser_bit_timer.sv | 31 +++
 rtl/bus_serializer.sv | 111 +++++++++++
 3 files changed

// File: rtl/bus_ser_pkg.sv
// Shared types and helpers for the bus serializer.
package bus_ser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_ser_bit_timer.sv
// Bit-period down-counter: o_tick marks the last cycle of each serial bit.
module bus_ser_bit_timer
  import bus_ser_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned    CW     = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Reload on restart or at the end of each bit period, otherwise count down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/bus_serializer.sv
// Parallel-to-serial framer: start, LSB-first data, optional even parity, stop.
module bus_serializer
  import bus_ser_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    IW       = cnt_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [IW-1:0]    r_bit_idx;
  logic [IW-1:0]    w_bit_idx_next;
  logic             r_parity;
  logic             w_parity_next;
  logic             r_serial;
  logic             w_serial_next;
  logic             r_done;
  logic             w_tick;
  logic             w_accept;
  logic             w_last_bit;

  bus_ser_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (r_state == ST_IDLE),
    .o_tick    (w_tick)
  );

  assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_tick);
  assign w_accept   = in_valid && in_ready;
  assign w_last_bit = (r_bit_idx == LAST_IDX);
  assign serial     = r_serial;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;

  // Next-state decode; each non-idle state advances only on the bit tick.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_next = ST_START;
      ST_START:  if (w_tick) w_state_next = ST_DATA;
      ST_DATA:   if (w_tick && w_last_bit)
                   w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_tick) w_state_next = ST_STOP;
      ST_STOP:   if (w_tick) w_state_next = w_accept ? ST_START : ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Datapath next values; serial is registered from the next state so the
  // start bit appears the cycle after the accept edge.
  always_comb begin
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_parity_next  = r_parity;
    if (w_accept) begin
      w_shift_next   = in_data;
      w_bit_idx_next = '0;
      w_parity_next  = 1'b0;
    end else if ((r_state == ST_DATA) && w_tick) begin
      w_shift_next   = r_shift >> 1;
      w_parity_next  = r_parity ^ r_shift[0];
      if (!w_last_bit) begin
        w_bit_idx_next = r_bit_idx + IW'(1);
      end
    end
    case (w_state_next)
      ST_START:  w_serial_next = 1'b0;
      ST_DATA:   w_serial_next = w_shift_next[0];
      ST_PARITY: w_serial_next = w_parity_next;
      default:   w_serial_next = 1'b1;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_parity  <= 1'b0;
      r_serial  <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_parity  <= w_parity_next;
      r_serial  <= w_serial_next;
      r_done    <= (r_state == ST_STOP) && w_tick;
    end
  end

endmodule
